// File: rtl/clk_gate_pkg.sv
// Shared types and sizing helpers for the clock-gate enable controller.
package clk_gate_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_OFF   = 2'd2,
      ST_WAKE  = 2'd3
   } state_e;

   // Width that holds every value up to the larger of the two intervals.
   function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
      int max_cycles;
      max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
      return $clog2(max_cycles + 1);
   endfunction

endpackage : clk_gate_pkg

// File: rtl/clk_gate_ctrl.sv
// Idle-detecting controller that drives the enable of the clock-gating cell,
// with a sleep handshake toward the gated domain and a settle interval on wake.
module clk_gate_ctrl
   import clk_gate_pkg::*;
#(
   parameter int IDLE_CYCLES = 16,
   parameter int WAKE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       busy_i,
   input  logic       req_i,
   input  logic       force_on_i,
   input  logic       sleep_ack_i,
   output logic       gate_en_o,
   output logic       sleep_req_o,
   output logic       ready_o,
   output logic [1:0] state_o
);

   localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gate_en_q, gate_en_d;
   logic             ready_q, ready_d;
   logic             sleep_req_q, sleep_req_d;

   logic idle;
   logic wake_cond;

   assign idle      = ~(busy_i | req_i | force_on_i);
   assign wake_cond = req_i | force_on_i;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         ST_RUN: begin
            if (!idle) begin
               cnt_d = '0;
            end else if (cnt_q == IDLE_LAST) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (wake_cond) begin
               state_d = ST_RUN;
            end else if (sleep_ack_i) begin
               state_d = ST_OFF;
            end
         end
         ST_OFF: begin
            if (wake_cond) begin
               state_d = ST_WAKE;
               cnt_d   = '0;
            end
         end
         ST_WAKE: begin
            if (cnt_q == WAKE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase

      // Outputs are decoded from the next state so each lands in its own flop;
      // the gating latch then only ever sees a clean registered enable.
      gate_en_d   = (state_d != ST_OFF);
      ready_d     = (state_d == ST_RUN);
      sleep_req_d = (state_d == ST_DRAIN);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         gate_en_q   <= 1'b1;
         ready_q     <= 1'b1;
         sleep_req_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gate_en_q   <= gate_en_d;
         ready_q     <= ready_d;
         sleep_req_q <= sleep_req_d;
      end
   end

   assign gate_en_o   = gate_en_q;
   assign ready_o     = ready_q;
   assign sleep_req_o = sleep_req_q;
   assign state_o     = state_q;

endmodule : clk_gate_ctrl

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: driver pushes model predictions per cycle,
// a monitor pops and compares them against the registered outputs.
module tb_clk_gate_ctrl;

   localparam int IDLE_CYCLES = 4;
   localparam int WAKE_CYCLES = 2;

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_OFF   = 2;
   localparam int M_WAKE  = 3;

   typedef struct {
      logic       gate_en;
      logic       ready;
      logic       sleep_req;
      logic [1:0] state;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       busy_i;
   logic       req_i;
   logic       force_on_i;
   logic       sleep_ack_i;
   logic       gate_en_o;
   logic       sleep_req_o;
   logic       ready_o;
   logic [1:0] state_o;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: mode plus how long we have been idle / settling.
   int mode        = M_RUN;
   int idle_streak = 0;
   int wake_done   = 0;

   clk_gate_ctrl #(
      .IDLE_CYCLES(IDLE_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .busy_i     (busy_i),
      .req_i      (req_i),
      .force_on_i (force_on_i),
      .sleep_ack_i(sleep_ack_i),
      .gate_en_o  (gate_en_o),
      .sleep_req_o(sleep_req_o),
      .ready_o    (ready_o),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [1:0] actual, input logic [1:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Advance the model by one clock edge with the given inputs sampled.
   task automatic model_edge(input logic b, input logic r, input logic f, input logic a, input logic rs);
      bit wake_in;
      wake_in = r | f;
      if (rs) begin
         mode        = M_RUN;
         idle_streak = 0;
         wake_done   = 0;
      end else begin
         case (mode)
            M_RUN: begin
               if (b | r | f) begin
                  idle_streak = 0;
               end else begin
                  idle_streak++;
                  if (idle_streak == IDLE_CYCLES) begin
                     mode        = M_DRAIN;
                     idle_streak = 0;
                  end
               end
            end
            M_DRAIN: begin
               if (wake_in) mode = M_RUN;
               else if (a)  mode = M_OFF;
            end
            M_OFF: begin
               if (wake_in) begin
                  mode      = M_WAKE;
                  wake_done = 0;
               end
            end
            default: begin
               wake_done++;
               if (wake_done == WAKE_CYCLES) begin
                  mode        = M_RUN;
                  idle_streak = 0;
               end
            end
         endcase
      end
   endtask

   task automatic step(input logic b, input logic r, input logic f, input logic a, input logic rs);
      exp_t e;
      @(negedge clk);
      busy_i      = b;
      req_i       = r;
      force_on_i  = f;
      sleep_ack_i = a;
      rst         = rs;
      model_edge(b, r, f, a, rs);
      e.gate_en   = (mode != M_OFF);
      e.ready     = (mode == M_RUN);
      e.sleep_req = (mode == M_DRAIN);
      e.state     = 2'(mode);
      exp_q.push_back(e);
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Monitor: outputs are registered, so compare shortly after every edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("gate_en_o",   {1'b0, gate_en_o},   {1'b0, e.gate_en});
         check("ready_o",     {1'b0, ready_o},     {1'b0, e.ready});
         check("sleep_req_o", {1'b0, sleep_req_o}, {1'b0, e.sleep_req});
         check("state_o",     state_o,             e.state);
      end
   end

   initial begin
      rst         = 1'b1;
      busy_i      = 1'b0;
      req_i       = 1'b0;
      force_on_i  = 1'b0;
      sleep_ack_i = 1'b0;

      // Reset, idle into DRAIN, ack into OFF.
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      idle_steps(IDLE_CYCLES);
      step(0, 0, 0, 1, 0);

      // Held request from OFF walks through WAKE back to RUN.
      for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);

      // A busy pulse restarts the idle count.
      idle_steps(3);
      step(1, 0, 0, 0, 0);
      idle_steps(IDLE_CYCLES + 1);

      // In DRAIN: abort beats ack in the same cycle.
      step(0, 1, 0, 1, 0);
      idle_steps(IDLE_CYCLES);
      step(0, 0, 0, 1, 0);

      // Reset while OFF.
      step(0, 0, 0, 0, 1);

      // Reset while WAKE.
      idle_steps(IDLE_CYCLES);
      step(0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 1);

      // force_on holds the domain awake, then idle resumes the count.
      for (int i = 0; i < 100; i++) step(0, 0, 1, 0, 0);
      idle_steps(IDLE_CYCLES + 1);

      // Randomized traffic biased toward long idle stretches.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(7) == 0),
              ($urandom_range(15) == 0),
              ($urandom_range(23) == 0),
              ($urandom_range(1) == 0),
              ($urandom_range(99) == 0));
      end

      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", 2'(exp_q.size()), 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_clk_gate_ctrl

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Idle-detecting controller that produces the enable for the clock-gating cell. It watches activity and work requests around a gated domain and, after a programmable idle interval, negotiates a sleep handshake with that domain before dropping `gate_en_o`. On a new request it re-enables the clock and holds `ready_o` low for a settle interval before reporting the domain usable. It sits in the always-on `clk` domain, and its `gate_en_o` drives the `en` input of `clock_gating`.

## Interface
- `IDLE_CYCLES`, 16: consecutive idle cycles in RUN before sleep is requested; must be at least 1.
- `WAKE_CYCLES`, 2: cycles with the clock enabled before `ready_o` rises after wake; must be at least 1.
- `clk`  in  1  ungated clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `busy_i`  in  1  gated domain is active; any high cycle counts as activity.
- `req_i`  in  1  work request (level); the requester holds it until it sees `ready_o`=1.
- `force_on_i`  in  1  inhibits sleep while high.
- `sleep_ack_i`  in  1  gated domain confirms it is quiesced.
- `gate_en_o`  out  1  clock enable to the gating cell.
- `sleep_req_o`  out  1  request to the gated domain to quiesce.
- `ready_o`  out  1  clock is running and settled.
- `state_o`  out  2  current FSM state, for debug.

## Operation
- The FSM has four states: RUN, DRAIN, OFF and WAKE. A single counter `cnt` is shared by RUN (idle count) and WAKE (settle count).
- A cycle is idle when `busy_i`, `req_i` and `force_on_i` are all 0.
- Outputs per state:
  - RUN: `gate_en_o`=1, `ready_o`=1, `sleep_req_o`=0.
  - DRAIN: `gate_en_o`=1, `ready_o`=0, `sleep_req_o`=1.
  - OFF: all three outputs 0.
  - WAKE: `gate_en_o`=1, `ready_o`=0, `sleep_req_o`=0.
- RUN:
  - A non-idle cycle clears `cnt`.
  - An idle cycle with `cnt`==IDLE_CYCLES-1 moves the FSM to DRAIN and clears `cnt`.
  - Any other idle cycle increments `cnt`.
- DRAIN:
  - `req_i` or `force_on_i` high moves to RUN (abort). Abort has priority over `sleep_ack_i` in the same cycle.
  - Otherwise, `sleep_ack_i` high moves to OFF.
  - Otherwise the FSM stays in DRAIN. `busy_i` alone does not abort; the gated domain finishes its work and then acks.
- OFF: `req_i` or `force_on_i` high moves to WAKE and clears `cnt`. `sleep_ack_i` and `busy_i` are ignored.
- WAKE:
  - `cnt`==WAKE_CYCLES-1 moves to RUN and clears `cnt`; otherwise `cnt` increments.
  - Wake cannot be aborted; in-flight requests simply wait for `ready_o`.
- Reset puts the FSM in RUN with `cnt`=0. Reset values: `gate_en_o`=1, `ready_o`=1, `sleep_req_o`=0, `state_o`=RUN. This holds from any state, including mid-DRAIN or mid-WAKE.
- `cnt` width is `$clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1)`. `cnt` never wraps; it saturates by construction.

## Timing
- All outputs are registered, directly from state flops, so `gate_en_o` is glitch-free toward the gating latch.
- Idle to sleep request: with idle sampled on edges 1..IDLE_CYCLES, `sleep_req_o` is high after edge IDLE_CYCLES.
- Ack to clock off: `sleep_ack_i` sampled high at edge k gives `gate_en_o`=0 after edge k.
- Wake latency: `req_i` sampled in OFF at edge k gives `gate_en_o`=1 after edge k and `ready_o`=1 after edge k+WAKE_CYCLES.
- Abort: `req_i` sampled in DRAIN at edge k gives `sleep_req_o`=0 and `ready_o`=1 after edge k; `gate_en_o` never falls.
- `sleep_ack_i` is only meaningful while `sleep_req_o`=1.

## Structure
- Package `clk_gate_pkg`:
  - 2-bit state type: RUN=2'd0, DRAIN=2'd1, OFF=2'd2, WAKE=2'd3.
  - The function computing the counter width.
- The controller is one flat module. No sub-module is needed; the counter is a few lines inside the FSM.
- The integration wrapper, outside this block, connects `gate_en_o` to `clock_gating.en`.

## Test plan
All scenarios use IDLE_CYCLES=4 and WAKE_CYCLES=2.
1. Hold `rst`=1 for 2 cycles, then all inputs 0 → `sleep_req_o` rises at the 4th edge after reset release. `sleep_ack_i`=1 on the next edge → `gate_en_o`=0 and `state_o`=OFF after that edge.
2. Idle for 3 cycles, then `busy_i`=1 for 1 cycle, then idle → `sleep_req_o` rises 4 edges after the busy pulse, not earlier.
3. In DRAIN, drive `req_i`=1 and `sleep_ack_i`=1 on the same cycle → next state RUN, `ready_o`=1, `gate_en_o` stays 1 throughout.
4. In OFF, pulse `req_i` and hold it → `gate_en_o`=1 after 1 edge, `ready_o`=1 after 3 edges, `state_o` sequence OFF, WAKE, WAKE, RUN.
5. `force_on_i`=1 with `busy_i`=0 for 100 cycles → `state_o` remains RUN and `sleep_req_o` stays 0. After `force_on_i` drops, sleep is requested after 4 idle edges.
6. Assert `rst` while in WAKE, and separately while in OFF → after the reset edge: RUN, `gate_en_o`=1, `ready_o`=1, `sleep_req_o`=0.
